// File: rtl/serial_arb_pkg.sv
// Shared types and helpers for the serial bus arbiter.
//   t_arb_state : arbiter FSM states
//   req_bits()  : width of a requester index for a given requester count
package serial_arb_pkg;

   typedef enum logic [1:0] {
      Idle,
      Granted,
      Release
   } t_arb_state;

   // Index width, never narrower than one bit.
   function automatic int unsigned req_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin pick: the first requester at or after last+1,
// wrapping modulo NUM_REQ (works for non-power-of-two counts).
//   req   : request vector
//   last  : index granted most recently
//   valid : at least one request present
//   idx   : winning requester index
module arb_rr_select
   import serial_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned REQ_BITS = req_bits(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [REQ_BITS-1:0] last,
   output logic                valid,
   output logic [REQ_BITS-1:0] idx
);

   localparam int unsigned SUM_BITS = REQ_BITS + 1;

   logic [SUM_BITS-1:0] cand;

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = SUM_BITS'(last) + SUM_BITS'(k);
         if (cand >= SUM_BITS'(NUM_REQ)) begin
            cand = cand - SUM_BITS'(NUM_REQ);
         end
         if (req[cand[REQ_BITS-1:0]]) begin
            valid = 1'b1;
            idx   = cand[REQ_BITS-1:0];
         end
      end
   end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin sharing of one serial bus master between NUM_REQ requesters,
// one whole transaction per grant. The granted requester's enable/data/addr
// go to the master and the master handshake comes back to it alone; the
// forwarding paths are combinational, the grant vector is registered.
//   in_clk, in_rst       : clock, asynchronous active-high reset
//   in_req_enable/data/addr : per-requester transaction inputs
//   out_req_ready/next_word : master handshake, granted requester only
//   out_grant            : one-hot grant (zero when idle)
//   in_bus_ready/next_word  : handshake from the master
//   out_bus_enable/data/addr: transaction towards the master
module serial_bus_arbiter
   import serial_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned BUS_BITS  = 8,
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned REQ_BITS  = req_bits(NUM_REQ)
) (
   input  logic                               in_clk,
   input  logic                               in_rst,
   input  logic [NUM_REQ-1:0]                 in_req_enable,
   input  logic [NUM_REQ-1:0][BUS_BITS-1:0]   in_req_data,
   input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  in_req_addr,
   output logic [NUM_REQ-1:0]                 out_req_ready,
   output logic [NUM_REQ-1:0]                 out_req_next_word,
   output logic [NUM_REQ-1:0]                 out_grant,
   input  logic                               in_bus_ready,
   input  logic                               in_bus_next_word,
   output logic                               out_bus_enable,
   output logic [BUS_BITS-1:0]                out_bus_data,
   output logic [ADDR_BITS-1:0]               out_bus_addr
);

   // Reset "last" to the top index so requester 0 wins first.
   localparam logic [REQ_BITS-1:0] LAST_RST = REQ_BITS'(NUM_REQ - 1);

   t_arb_state          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [REQ_BITS-1:0] last_q, last_d;
   logic [REQ_BITS-1:0] sel_idx;
   logic                sel_valid;

   arb_rr_select #(
      .NUM_REQ  (NUM_REQ),
      .REQ_BITS (REQ_BITS)
   ) u_select (
      .req   (in_req_enable),
      .last  (last_q),
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   // State, grant and last-winner registers.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q <= Idle;
         grant_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Next state and forwarding muxes; last_q doubles as the granted index.
   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      last_d            = last_q;
      out_bus_enable    = 1'b0;
      out_bus_data      = '0;
      out_bus_addr      = '0;
      out_req_ready     = '0;
      out_req_next_word = '0;
      unique case (state_q)
         Idle: begin
            if (sel_valid && in_bus_ready) begin
               grant_d = NUM_REQ'(1) << sel_idx;
               last_d  = sel_idx;
               state_d = Granted;
            end
         end
         Granted: begin
            out_bus_enable    = in_req_enable[last_q];
            out_bus_data      = in_req_data[last_q];
            out_bus_addr      = in_req_addr[last_q];
            out_req_ready     = grant_q & {NUM_REQ{in_bus_ready}};
            out_req_next_word = grant_q & {NUM_REQ{in_bus_next_word}};
            if (!in_req_enable[last_q]) begin
               state_d = Release;
            end
         end
         Release: begin
            // Enable is dropped; ready still reaches the owner so it sees completion.
            out_bus_data  = in_req_data[last_q];
            out_bus_addr  = in_req_addr[last_q];
            out_req_ready = grant_q & {NUM_REQ{in_bus_ready}};
            if (in_bus_ready) begin
               grant_d = '0;
               state_d = Idle;
            end
         end
         default: begin
            state_d = Idle;
            grant_d = '0;
         end
      endcase
   end

   assign out_grant = grant_q;

endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Round-robin arbiter that shares one serial bus master (enable/data/ready/next_word byte interface) between several requesters, e.g. the OLED display controller and a sensor reader on the same I2C/SPI master. It grants the bus for one whole transaction at a time, forwards the granted requester's byte stream and device address to the master, and routes the master's handshake back only to the granted requester. Every other requester sees an idle bus and stalls.

## Interface
- NUM_REQ, 2: number of requesters; must be >= 2.
- BUS_BITS, 8: byte width of the bus data.
- ADDR_BITS, 8: width of the device address forwarded to the master.
- REQ_BITS, $clog2(NUM_REQ): width of the requester index.

- in_clk  in  1  system clock
- in_rst  in  1  asynchronous, active-high reset
- in_req_enable  in  NUM_REQ  per-requester bus enable; high for the whole transaction
- in_req_data  in  NUM_REQ x BUS_BITS  per-requester byte to send
- in_req_addr  in  NUM_REQ x ADDR_BITS  per-requester device address
- out_req_ready  out  NUM_REQ  master ready, forwarded to the granted requester only
- out_req_next_word  out  NUM_REQ  master next-word strobe, forwarded to the granted requester only
- out_grant  out  NUM_REQ  one-hot grant vector; all zero when no grant
- in_bus_ready  in  1  master idle/finished
- in_bus_next_word  in  1  master accepted current byte
- out_bus_enable  out  1  enable to master
- out_bus_data  out  BUS_BITS  byte to master
- out_bus_addr  out  ADDR_BITS  device address to master

## Operation
- States:
  - Idle: no requester granted.
  - Granted: one requester owns the bus.
  - Release: the granted requester has finished and the master is draining.
- Idle:
  - out_bus_enable = 0; all out_req_* = 0.
  - If any in_req_enable is high and in_bus_ready = 1, select the first requesting index starting at (last + 1) mod NUM_REQ.
  - Register the selection as grant and last, then go to Granted.
- Granted (grant g):
  - out_bus_enable = in_req_enable[g]; out_bus_data = in_req_data[g]; out_bus_addr = in_req_addr[g].
  - out_req_ready[g] = in_bus_ready; out_req_next_word[g] = in_bus_next_word.
  - Every other requester sees 0 on both handshake outputs.
  - When in_req_enable[g] = 0, go to Release.
- Release:
  - out_bus_enable = 0; out_bus_data and out_bus_addr hold requester g's values.
  - out_req_ready[g] still follows in_bus_ready, so the requester can observe completion.
  - When in_bus_ready = 1, clear the grant and go to Idle.
- Requests from non-granted requesters are never dropped. They stay pending (enable held high) until they win.
- When out_bus_enable = 0 the master ignores out_bus_data, so no zeroing of out_bus_data is required.
- Reset state:
  - state Idle, grant none, last = NUM_REQ-1, so requester 0 wins first.
  - All outputs 0.
- Reset mid-transaction: out_bus_enable drops asynchronously and the grant is lost. The master is expected to be reset by the same in_rst.

## Timing
- Grant latency:
  - Request seen in Idle with in_bus_ready = 1 at edge t: out_grant is valid after edge t+1.
  - out_bus_enable is forwarded combinationally from cycle t+1.
- Forwarding in Granted is purely combinational, with zero added latency in both directions. in_bus_next_word reaches out_req_next_word[g] in the same cycle.
- End of transaction:
  - in_req_enable[g] falls in cycle t: out_bus_enable falls in the same cycle t; state is Release from t+1.
  - in_bus_ready = 1 in Release at edge u: Idle from u+1; the next grant is registered at u+2 at the earliest.
- Simultaneous requests in Idle: round-robin order. Two requesters that request continuously alternate grants.
- A requester that re-raises enable in the same cycle its own grant ends does not keep the bus. It re-arbitrates in Idle.
- If in_bus_ready = 0 in Idle, no grant is issued until the master is ready.
- Index arithmetic is modulo NUM_REQ and works for non-power-of-two NUM_REQ. The wrap from NUM_REQ-1 goes to 0.

## Structure
- Package serial_arb_pkg contains:
  - enum t_arb_state {Idle, Granted, Release}
  - the REQ_BITS helper function
- Sub-module arb_rr_select is combinational: inputs are the request vector and last index; outputs are a valid flag and the winning index.
- The top level holds the state, grant and last registers and the forwarding muxes.

## Test plan
- Single requester: req0 sends 3 bytes; the master stub pulses next_word per byte. Expect out_bus_data to show the 3 bytes in order, out_grant = 01, and Idle after ready.
- Simultaneous req0 and req1 after reset: req0 is granted first. out_req_next_word[1] stays 0 for the whole req0 transaction. req1 is granted 2 cycles after release ready.
- Continuous requests from both with NUM_REQ = 2: grants alternate 0, 1, 0, 1 over 4 transactions.
- NUM_REQ = 3, last = 2, requests at 1 and 2 only: grant goes to 1, then 2, with no stall on absent requester 0.
- in_bus_ready held 0 for 10 cycles in Release: no new grant, and out_bus_enable stays 0 until ready rises.
- in_rst asserted mid-byte in Granted: all outputs go to 0 immediately. After release, req1 alone is granted normally and req0 wins the first tie.
